note_sustain_mixer: RTL and testbench

- Sits directly downstream of the per-beat sequencer players.
- Merges the note codes from all players into one note stream using fixed priority, and holds each note for a programmable sustain tail.
- Inserts a short silent articulation gap between notes, then drives the tone generator.
- In piano mode (sequencer_on=0) it passes the piano note through, registered.

---
 rtl/sass_note_pkg.sv | 21 ++
 rtl/note_sustain_mixer_if.sv | 15 +
 rtl/note_priority_select.sv | 16 +
 rtl/note_sustain_mixer.sv | 97 +++++++++
 tb/tb_note_sustain_mixer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sass_note_pkg.sv
// sass_note_pkg: note codes, note type and mixer FSM states shared by the
// sequencer players, the sustain mixer and the tone generator.
package sass_note_pkg;
  typedef logic [3:0] note_t;
  localparam note_t OFF      = 4'd0;
  localparam note_t LOW_C    = 4'd1;
  localparam note_t LOW_CS   = 4'd2;
  localparam note_t LOW_D    = 4'd3;
  localparam note_t LOW_DS   = 4'd4;
  localparam note_t LOW_E    = 4'd5;
  localparam note_t LOW_F    = 4'd6;
  localparam note_t LOW_FS   = 4'd7;
  localparam note_t LOW_G    = 4'd8;
  localparam note_t LOW_GS   = 4'd9;
  localparam note_t LOW_A    = 4'd10;
  localparam note_t LOW_AS   = 4'd11;
  localparam note_t LOW_B    = 4'd12;
  localparam note_t HIGH_C   = 4'd13;
  localparam note_t NOTE_MAX = 4'd13;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} mixer_state_t;
endpackage

// File: rtl/note_sustain_mixer_if.sv
// note_sustain_mixer_if: player/piano/beat inputs and tone-generator outputs of the mixer.
interface note_sustain_mixer_if #(parameter int NUM_PLAYERS = 8);
  import sass_note_pkg::*;
  logic [4*NUM_PLAYERS-1:0] player_notes;
  note_t piano_note;
  logic [3:0] beat;
  logic sequencer_on;
  note_t note_out;
  logic note_active;
  logic new_note;
  modport master (output player_notes, piano_note, beat, sequencer_on,
                  input  note_out, note_active, new_note);
  modport slave  (input  player_notes, piano_note, beat, sequencer_on,
                  output note_out, note_active, new_note);
endinterface

// File: rtl/note_priority_select.sv
// note_priority_select: picks the note of the lowest-index player holding a legal code (1..13).
module note_priority_select
  import sass_note_pkg::*;
#(
  parameter int NUM_PLAYERS = 8
) (
  input  logic [4*NUM_PLAYERS-1:0] player_notes_i,
  output note_t                    cand_o
);
  always_comb begin
    cand_o = OFF;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      cand_o = (player_notes_i[4*i +: 4] != OFF && player_notes_i[4*i +: 4] <= NOTE_MAX) ?
               player_notes_i[4*i +: 4] : cand_o;
  end
endmodule

// File: rtl/note_sustain_mixer.sv
// note_sustain_mixer: merges player notes by priority, sustains each note, inserts an
// articulation gap, and passes the piano note through when the sequencer is off.
module note_sustain_mixer
  import sass_note_pkg::*;
#(
  parameter int NUM_PLAYERS    = 8,
  parameter int SUSTAIN_CYCLES = 2500,
  parameter int GAP_CYCLES     = 100,
  parameter int CNT_W          = 12
) (
  input  logic                clk,
  input  logic                n_rst,
  note_sustain_mixer_if.slave bus
);
  if (SUSTAIN_CYCLES < 1 || GAP_CYCLES < 0 || SUSTAIN_CYCLES - 1 >= (1 << CNT_W) ||
      GAP_CYCLES - 1 >= (1 << CNT_W)) begin : g_bad_params
    $error("note_sustain_mixer: CNT_W too small or SUSTAIN_CYCLES < 1");
  end
  localparam logic [CNT_W-1:0] SUS_LD = CNT_W'(SUSTAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  mixer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  note_t            held_q, held_d, note_q, note_d, cand;
  logic [3:0]       beat_q;
  logic             active_q, new_q, new_d, load, beat_chg;
  note_priority_select #(.NUM_PLAYERS(NUM_PLAYERS)) u_sel (
    .player_notes_i(bus.player_notes),
    .cand_o        (cand)
  );
  assign beat_chg = bus.beat != beat_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      held_q   <= OFF;
      beat_q   <= '0;
      note_q   <= OFF;
      active_q <= 1'b0;
      new_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      beat_q   <= bus.beat;
      note_q   <= note_d;
      active_q <= note_d != OFF;
      new_q    <= new_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    load    = 1'b0;
    if (!bus.sequencer_on) begin
      state_d = IDLE;
      cnt_d   = '0;
      held_d  = OFF;
    end else begin
      case (state_q)
        IDLE: load = cand != OFF;
        HOLD: begin
          if (cand != OFF && (cand != held_q || beat_chg)) load = 1'b1;
          else if (cand != OFF) cnt_d = SUS_LD;
          else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else begin
            state_d = GAP_CYCLES > 0 ? GAP : IDLE;
            cnt_d   = GAP_LD;
          end
        end
        GAP: begin
          // A new note cuts the gap short rather than being dropped.
          if (cand != OFF) load = 1'b1;
          else if (cnt_q == '0) state_d = IDLE;
          else cnt_d = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (load) begin
        state_d = HOLD;
        held_d  = cand;
        cnt_d   = SUS_LD;
      end
    end
  end
  always_comb begin
    note_d = !bus.sequencer_on ? (bus.piano_note > NOTE_MAX ? OFF : bus.piano_note) :
             (state_d == HOLD ? held_d : OFF);
    new_d  = !bus.sequencer_on ? (note_d != OFF && note_d != note_q) : load;
  end
  assign bus.note_out    = note_q;
  assign bus.note_active = active_q;
  assign bus.new_note    = new_q;
endmodule

// File: tb/tb_note_sustain_mixer.sv
// tb_note_sustain_mixer: directed vector table, hand-written reset sequence, and random
// stimulus checked against a cycle-timeline reference model of the mixer.
module tb_note_sustain_mixer;
  import sass_note_pkg::*;
  localparam int NP = 8, S = 4, G = 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  note_sustain_mixer_if #(.NUM_PLAYERS(NP)) bus ();
  note_sustain_mixer #(.NUM_PLAYERS(NP), .SUSTAIN_CYCLES(S), .GAP_CYCLES(G), .CNT_W(12)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );
  int checks = 0, errors = 0;
  int cyc, on_until;
  note_t m_held, m_note;
  logic m_new;
  logic [3:0] m_beat_q;
  typedef struct {
    logic seq; logic [31:0] players; note_t piano; logic [3:0] beat;
    note_t exp_note; logic exp_new; logic cs; mixer_state_t st;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(logic seq, logic [31:0] p, note_t pn, logic [3:0] b,
                              note_t en, logic ew, logic cs = 1'b0, mixer_state_t st = IDLE);
    vec_t v;
    v.seq = seq; v.players = p; v.piano = pn; v.beat = b;
    v.exp_note = en; v.exp_new = ew; v.cs = cs; v.st = st;
    return v;
  endfunction
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic note_t pick(logic [31:0] p);
    for (int i = 0; i < NP; i++)
      if (p[4*i +: 4] >= 4'd1 && p[4*i +: 4] <= 4'd13) return p[4*i +: 4];
    return 4'd0;
  endfunction
  task automatic model_reset();
    cyc = 0; on_until = -1; m_held = 0; m_note = 0; m_new = 0; m_beat_q = 0;
  endtask
  // The note is audible while the cycle index is <= on_until; GAP and IDLE look alike outside.
  task automatic model_step();
    note_t c;
    bit hold;
    c = pick(bus.player_notes);
    if (!bus.sequencer_on) begin
      note_t n;
      n = bus.piano_note <= 4'd13 ? bus.piano_note : 4'd0;
      m_new = n != 0 && n != m_note;
      m_note = n;
      on_until = -1;
    end else begin
      hold = on_until >= cyc;
      m_new = 1'b0;
      if (c != 0 && (!hold || c != m_held || bus.beat != m_beat_q)) begin
        m_held = c; on_until = cyc + S; m_new = 1'b1;
      end else if (c != 0) on_until = cyc + S;
      m_note = on_until >= cyc + 1 ? m_held : 4'd0;
    end
    m_beat_q = bus.beat;
    cyc++;
  endtask
  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " model note"}, 8'(bus.note_out), 8'(m_note));
    check({tag, " model new"}, 8'(bus.new_note), 8'(m_new));
    check({tag, " model active"}, 8'(bus.note_active), 8'(m_note != 0));
  endtask
  task automatic drive(logic seq, logic [31:0] p, note_t pn, logic [3:0] b);
    bus.sequencer_on = seq; bus.player_notes = p; bus.piano_note = pn; bus.beat = b;
  endtask
  initial begin
    logic [31:0] players;
    logic [3:0] beat;
    note_t piano;
    logic seq;
    drive(1'b1, 32'h0, 4'd0, 4'd0);
    vt.push_back(mk(1, 32'h0000_A000, 0, 0, 10, 1));
    vt.push_back(mk(1, 32'h0, 0, 0, 10, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 10, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 10, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, GAP));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, IDLE));
    vt.push_back(mk(1, 32'h0010_0600, 0, 0, 6, 1));
    vt.push_back(mk(1, 32'h0010_0000, 0, 0, 1, 1));
    vt.push_back(mk(1, 32'h0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, GAP));
    vt.push_back(mk(1, 32'h0000_00C0, 0, 0, 12, 1, 1, HOLD));
    vt.push_back(mk(1, 32'h0, 0, 0, 12, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 12, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 12, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, IDLE));
    vt.push_back(mk(1, 32'h3, 0, 0, 3, 1));
    vt.push_back(mk(1, 32'h3, 0, 1, 3, 1));
    vt.push_back(mk(1, 32'h3, 0, 1, 3, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 3, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 3, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 3, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 0, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 0, 0));
    vt.push_back(mk(1, 32'h0, 0, 1, 0, 0));
    vt.push_back(mk(1, 32'hF, 0, 1, 0, 0));
    vt.push_back(mk(1, 32'hEF, 0, 1, 0, 0, 1, IDLE));
    vt.push_back(mk(1, 32'h0, 0, 1, 0, 0));
    vt.push_back(mk(1, 32'h0009_0000, 0, 1, 9, 1));
    vt.push_back(mk(0, 32'h0009_0000, 0, 1, 0, 0, 1, IDLE));
    vt.push_back(mk(0, 32'h0, 8, 1, 8, 1));
    vt.push_back(mk(0, 32'h0, 8, 1, 8, 0));
    vt.push_back(mk(0, 32'h0, 14, 1, 0, 0));
    vt.push_back(mk(0, 32'h0, 13, 1, 13, 1));
    vt.push_back(mk(1, 32'h0, 13, 1, 0, 0));
    vt.push_back(mk(1, 32'h0200_0000, 0, 7, 2, 1));
    vt.push_back(mk(1, 32'h0200_0000, 0, 0, 2, 1));
    vt.push_back(mk(1, 32'h0, 0, 0, 2, 0, 1, HOLD));
    #2;
    check("reset note", 8'(bus.note_out), 8'd0);
    check("reset active", 8'(bus.note_active), 8'd0);
    check("reset new", 8'(bus.new_note), 8'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].seq, vt[i].players, vt[i].piano, vt[i].beat);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d note", i), 8'(bus.note_out), 8'(vt[i].exp_note));
      check($sformatf("vec%0d new", i), 8'(bus.new_note), 8'(vt[i].exp_new));
      check($sformatf("vec%0d active", i), 8'(bus.note_active), 8'(vt[i].exp_note != 0));
      if (vt[i].cs) check($sformatf("vec%0d state", i), 8'(dut.state_q), 8'(vt[i].st));
    end
    drive(1'b1, 32'h5, 4'd0, 4'd0);
    tick("arm");
    drive(1'b1, 32'h0, 4'd0, 4'd0);
    tick("hold5");
    check("hold5 note", 8'(bus.note_out), 8'd5);
    #2;
    n_rst = 1'b0;
    #1;
    check("async rst note", 8'(bus.note_out), 8'd0);
    check("async rst active", 8'(bus.note_active), 8'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    drive(1'b0, 32'h0, 4'd8, 4'd0);
    tick("piano8");
    check("piano8 note", 8'(bus.note_out), 8'd8);
    check("piano8 new", 8'(bus.new_note), 8'd1);
    tick("piano8b");
    check("piano8b new", 8'(bus.new_note), 8'd0);
    players = 32'h0; beat = 4'd0; piano = 4'd0; seq = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < NP; j++)
          players[4*j +: 4] = $urandom_range(0, 9) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 15) == 0) beat = (beat + 4'd1) & 4'd7;
      if ($urandom_range(0, 7) == 0) piano = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) seq = ~seq;
      drive(seq, players, piano, beat);
      tick("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
